_register_arbiter4: RTL
=======================

# _register_arbiter4

Round-robin controller that shares one 8-entry × 32-bit register bank among four requesters. Each granted requester performs exactly one read or write access. The bank is built from eight instances of the existing `_register32` storage element, with write-enable muxing added in this block. It sits between the per-requester request ports and the shared storage, and serialises all accesses to it.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; fixed at 4 in this revision.
- `DEPTH`, 8: number of 32-bit bank entries.
- `AW`, 3: address width, equal to log2(`DEPTH`).
- `DW`, 32: data width.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  4  per-requester access request; held high until grant.
- `we`  in  4  per-requester access type: 1 = write, 0 = read.
- `addr`  in  4×`AW` (12)  packed; requester i uses `addr[3i+2:3i]`.
- `wdata`  in  4×`DW` (128)  packed; requester i uses `wdata[32i+31:32i]`.
- `gnt`  out  4  one-hot grant, high for exactly one cycle.
- `rdata`  out  32  read result.
- `rvalid`  out  1  `rdata` is valid this cycle.
- `rid`  out  2  index of the requester that owns `rdata`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: if any `req` bit is high, pick a winner and go to GRANT; otherwise stay in IDLE.
  - GRANT: `gnt[w]` is high and the access executes. A write returns to IDLE; a read goes to RESP.
  - RESP: `rvalid`=1 and `rdata`/`rid` are presented for one cycle, then return to IDLE.
- Arbitration is round-robin. The search starts at pointer `ptr` and checks `ptr`, `ptr+1`, … mod 4; the first requester with `req` high wins. When the FSM enters GRANT, `ptr` is updated to `w+1` mod 4.
- The winner index, its `we`, `addr` and `wdata` are registered on the IDLE→GRANT edge. Inputs that change after that edge have no effect.
- Write: entry `addr` loads `wdata` at the end of the GRANT cycle. All other entries reload their own `q`, which is the mux-based enable around `_register32`.
- Read: the mux output `bank[addr]` is captured into the `rdata` register at the end of the GRANT cycle.
- A requester that keeps `req` high after its grant is treated as a new request. Because `ptr` has moved past it, it gets lower priority than the others.
- A `req` that drops before it is granted is simply not served. There is no queueing.
- Bank contents are not reset. A read of an entry that has never been written returns undefined data.
- `rdata` holds its last value while `rvalid`=0.

## Timing
- Reset values: state = IDLE, `ptr` = 0, `gnt` = 0, `rvalid` = 0, `rid` = 0, `rdata` = 0, `busy` = 0.
- Reset asserted mid-operation: the next edge forces IDLE.
  - A write pending in the GRANT cycle is suppressed and the bank is unchanged.
  - A pending read response is dropped.
- Latency, with `req` first seen high in IDLE at cycle t:
  - `gnt` is high at cycle t+1.
  - A written value is visible in the bank from t+2.
  - For a read, `rvalid`/`rdata` are valid at t+2.
- Throughput: one write every 2 cycles; one read every 3 cycles.
- Requests that arrive while `busy`=1 wait and are arbitrated in the next IDLE cycle.
- Accesses are strictly serialised, so a read granted after a write to the same address returns the new data.
- All four `req` bits rising together with `ptr`=0 produce the grant order 0, 1, 2, 3, 0, …

## Structure
- Shared package `_arb_pkg` contains:
  - constants `NREQ`, `DEPTH`, `AW`, `DW`;
  - the state type IDLE/GRANT/RESP.
- Sub-module `_rr_pick4` (combinational): inputs `req[3:0]` and `ptr[1:0]`; outputs `found` and `win[1:0]`.
- Bank storage uses eight `_register32` instances plus per-entry 2:1 input muxes. No new storage primitive is added.

## Test plan
- Reset, then requester 1 writes 0xDEADBEEF to addr 5 -> `gnt`=0010 for one cycle. Requester 1 then reads addr 5 -> `rvalid` two cycles after the read request is first seen in IDLE, with `rdata`=0xDEADBEEF and `rid`=1.
- All four `req` high (reads of addr 0) after reset, each requester dropping `req` after its grant -> grants in order 0001, 0010, 0100, 1000, each followed by a RESP cycle with `rid` = 0, 1, 2, 3.
- Requester 2 holds `req` continuously while requester 0 requests once -> after 2 wins, `ptr`=3, so requester 0 wins next, then 2 again. No starvation.
- Write 0x11111111 to addr 7, then 0x22222222 to addr 7 from another requester, then read addr 7 -> `rdata`=0x22222222. Entries 0–6 are unchanged.
- Assert `reset` during the GRANT cycle of a write of 0xCAFEF00D to addr 3 that holds 0x0 -> on the next edge state = IDLE, `gnt` = 0, `ptr` = 0, and a subsequent read of addr 3 returns 0x0.
- Pulse `req[3]` for one cycle while `busy`=1 -> no grant is ever issued to requester 3.

Source files
------------

// File: rtl/_arb_pkg.sv
// Shared constants and FSM state type for the four-way register-bank arbiter.
package _arb_pkg;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;
endpackage

// File: rtl/_register32.sv
// Plain 32-bit storage element; contents are intentionally not reset.
module _register32 (
  input  logic        clk,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk) q <= d;
endmodule

// File: rtl/_register_arbiter4_rr_pick4.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module _rr_pick4
  import _arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   win
);
  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + IW'(k);
      if (req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
endmodule

// File: rtl/_register_arbiter4.sv
// Round-robin arbiter serialising single read/write accesses from four
// requesters onto an 8 x 32-bit bank built from _register32 elements.
module _register_arbiter4
  import _arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     we,
  input  logic [NREQ*AW-1:0]  addr,
  input  logic [NREQ*DW-1:0]  wdata,
  output logic [NREQ-1:0]     gnt,
  output logic [DW-1:0]       rdata,
  output logic                rvalid,
  output logic [IW-1:0]       rid,
  output logic                busy
);
  state_t          state, state_n;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            found;
  logic [IW-1:0]   win;
  logic            take;
  logic [NREQ-1:0] gnt_n;
  logic            rvalid_n;
  logic            wr_en_c;
  logic [DW-1:0]   bank_q [DEPTH];
  logic [DW-1:0]   bank_d [DEPTH];

  _rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .win   (win)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_n  = state;
    gnt_n    = '0;
    rvalid_n = 1'b0;
    take     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = NREQ'(1) << win;
          take    = 1'b1;
        end
      end
      GRANT: begin
        state_n  = we_q ? IDLE : RESP;
        rvalid_n = ~we_q;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      rvalid <= rvalid_n;
      busy   <= (state_n != IDLE);
      // Winner's request is frozen here; later input changes are ignored.
      if (take) begin
        ptr     <= win + IW'(1);
        win_q   <= win;
        we_q    <= we[win];
        addr_q  <= addr[int'(win)*AW +: AW];
        wdata_q <= wdata[int'(win)*DW +: DW];
      end
      if (rvalid_n) begin
        rid   <= win_q;
        rdata <= bank_q[addr_q];
      end
    end
  end

  // Reset gates the write so an interrupted GRANT leaves the bank untouched.
  assign wr_en_c = (state == GRANT) && we_q && !reset;

  for (genvar i = 0; i < DEPTH; i++) begin : g_bank
    assign bank_d[i] = (wr_en_c && (addr_q == AW'(i))) ? wdata_q : bank_q[i];
    _register32 u_reg (
      .clk (clk),
      .d   (bank_d[i]),
      .q   (bank_q[i])
    );
  end
endmodule
